// File: rtl/vtim_gen_if.sv
// rtl/vtim_gen_if.sv - control/status bundle for the vtim_gen sync/gate/done timing generator
// Optional frame_cnt member exists only when VTIM_GEN_FRAME_CNT_EN is defined.
interface vtim_gen_if #(
    parameter int CNT_W = 16,
    parameter int FRM_W = 16
);
    logic             ena;
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] Tsync;
    logic [CNT_W-1:0] Tgdel;
    logic [CNT_W-1:0] Tgate;
    logic [CNT_W-1:0] Tlen;
    logic             Sync;
    logic             Gate;
    logic             Done;
    logic             busy;
    logic [2:0]       phase;
`ifdef VTIM_GEN_FRAME_CNT_EN
    logic [FRM_W-1:0] frame_cnt;
`endif

    modport master (
        output ena, start, cont, Tsync, Tgdel, Tgate, Tlen,
`ifdef VTIM_GEN_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  Sync, Gate, Done, busy, phase
    );

    modport slave (
        input  ena, start, cont, Tsync, Tgdel, Tgate, Tlen,
`ifdef VTIM_GEN_FRAME_CNT_EN
        output frame_cnt,
`endif
        output Sync, Gate, Done, busy, phase
    );
endinterface

// File: rtl/vtim_gen.sv
// rtl/vtim_gen.sv - programmable sync/gate-delay/gate/done period generator, one-shot or free-running
// Define VTIM_GEN_FRAME_CNT_EN to add the completed-period counter frame_cnt.
module vtim_gen #(
    parameter int CNT_W = 16,
    parameter int FRM_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    vtim_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_GDEL = 3'd2,
        ST_GATE = 3'd3,
        ST_LEN  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] sh_gdel_q, sh_gdel_d;
    logic [CNT_W-1:0] sh_gate_q, sh_gate_d;
    logic             done_q, done_d;
    logic             launch;

    // Tsync and Tlen are consumed by the counter loads at launch, so cnt/len_cnt
    // already hold their period-start snapshot; only the later phases need shadows.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sh_gdel_d = sh_gdel_q;
        sh_gate_d = sh_gate_q;
        done_d    = 1'b0;
        launch    = 1'b0;

        if (bus.ena) begin
            if (state_q == ST_IDLE) begin
                launch = bus.start | bus.cont;
            end else if (len_q == '0) begin
                // Period end overrides any phase transition pending this cycle.
                done_d = 1'b1;
                launch = bus.start | bus.cont;
                if (!launch) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end else begin
                len_d = len_q - CNT_ONE;
                case (state_q)
                    ST_SYNC: begin
                        if (cnt_q == '0) begin
                            state_d = ST_GDEL;
                            cnt_d   = sh_gdel_q;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ST_GDEL: begin
                        if (cnt_q == '0) begin
                            state_d = ST_GATE;
                            cnt_d   = sh_gate_q;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ST_GATE: begin
                        if (cnt_q == '0) begin
                            state_d = ST_LEN;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        if (launch) begin
            state_d   = ST_SYNC;
            cnt_d     = bus.Tsync;
            len_d     = bus.Tlen;
            sh_gdel_d = bus.Tgdel;
            sh_gate_d = bus.Tgate;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            sh_gdel_q <= '0;
            sh_gate_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sh_gdel_q <= sh_gdel_d;
            sh_gate_q <= sh_gate_d;
            done_q    <= done_d;
        end
    end

`ifdef VTIM_GEN_FRAME_CNT_EN
    localparam logic [FRM_W-1:0] FRM_ONE = {{(FRM_W-1){1'b0}}, 1'b1};

    logic [FRM_W-1:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (done_d) begin
            frame_d = frame_q + FRM_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign bus.frame_cnt = frame_q;
`endif

    assign bus.Sync  = (state_q == ST_SYNC);
    assign bus.Gate  = (state_q == ST_GATE);
    assign bus.Done  = done_q;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.phase = state_q;

endmodule

// File: tb/tb_vtim_gen.sv
// tb/tb_vtim_gen.sv - scoreboard bench for vtim_gen (frame_cnt checked when VTIM_GEN_FRAME_CNT_EN is defined)
module tb_vtim_gen;

    localparam int CNT_W = 16;
    localparam int FRM_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vtim_gen_if #(.CNT_W(CNT_W), .FRM_W(FRM_W)) bus ();

    vtim_gen #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [6:0]       vec;
        logic [FRM_W-1:0] frm;
        string            tag;
    } exp_t;

    exp_t             sb[$];
    int               n_run  = 0;
    int               n_fail = 0;
    string            scn    = "init";
    logic [FRM_W-1:0] exp_frm = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected vector {busy, Done, Gate, Sync, phase}
    function automatic logic [6:0] mk(input logic [2:0] ph, input logic dn);
        return {ph != 3'd0, dn, ph == 3'd3, ph == 3'd1, ph};
    endfunction

    // Phase of cycle c for a period starting with SYNC in cycle 1, by last cycle of each phase.
    function automatic logic [2:0] ph_rng(input int c, input int se, input int ge, input int gte, input int le);
        if (c < 1)    return 3'd0;
        if (c <= se)  return 3'd1;
        if (c <= ge)  return 3'd2;
        if (c <= gte) return 3'd3;
        if (c <= le)  return 3'd4;
        return 3'd0;
    endfunction

    task automatic set_t(input int ts, input int tg, input int tt, input int tl);
        bus.Tsync = CNT_W'(ts);
        bus.Tgdel = CNT_W'(tg);
        bus.Tgate = CNT_W'(tt);
        bus.Tlen  = CNT_W'(tl);
    endtask

    task automatic tick(input logic r, input logic e, input logic s, input logic c,
                        input logic [2:0] ph, input logic dn, input int idx);
        exp_t it;
        @(posedge clk);
        #1;
        rst       = r;
        bus.ena   = e;
        bus.start = s;
        bus.cont  = c;
        if (dn) exp_frm = exp_frm + 1'b1;
        it.vec = mk(ph, dn);
        it.frm = exp_frm;
        it.tag = $sformatf("%s_c%0d", scn, idx);
        sb.push_back(it);
        if (r) exp_frm = '0;
    endtask

    // Start asserted with reset to confirm reset dominates.
    task automatic reset_dut();
        repeat (2) begin
            @(posedge clk);
            #1;
            rst       = 1'b1;
            bus.ena   = 1'b1;
            bus.start = 1'b1;
            bus.cont  = 1'b0;
        end
        exp_frm = '0;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t it;
            it = sb.pop_front();
            chk(it.tag, {25'd0, bus.busy, bus.Done, bus.Gate, bus.Sync, bus.phase}, {25'd0, it.vec});
`ifdef VTIM_GEN_FRAME_CNT_EN
            chk({it.tag, "_frm"}, {30'd0, bus.frame_cnt}, {30'd0, it.frm});
`endif
        end
    end

    initial begin
        rst       = 1'b1;
        bus.ena   = 1'b0;
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        set_t(2, 1, 3, 11);
        reset_dut();

        scn = "oneshot";
        for (int c = 0; c <= 16; c++)
            tick(1'b0, 1'b1, c == 0, 1'b0, ph_rng(c, 3, 5, 9, 12), c == 13, c);

        scn = "trunc";
        set_t(2, 1, 3, 5);
        for (int c = 0; c <= 10; c++)
            tick(1'b0, 1'b1, c == 0, 1'b0, ph_rng(c, 3, 5, 6, 6), c == 7, c);

        scn = "tlen0";
        set_t(2, 1, 3, 0);
        for (int c = 0; c <= 4; c++)
            tick(1'b0, 1'b1, c == 0, 1'b0, ph_rng(c, 1, 1, 1, 1), c == 2, c);

        scn = "cont";
        set_t(2, 1, 3, 11);
        for (int c = 0; c <= 28; c++) begin
            tick(1'b0, 1'b1, c == 0, c <= 23,
                 (c <= 12) ? ph_rng(c, 3, 5, 9, 12) : ph_rng(c - 12, 3, 5, 6, 12),
                 (c == 13) || (c == 25), c);
            if (c == 5) bus.Tgate = '0;
        end
        set_t(2, 1, 3, 11);

        scn = "freeze";
        for (int c = 0; c <= 19; c++)
            tick(1'b0, !(c >= 2 && c <= 4), c == 0, 1'b0, ph_rng(c, 6, 8, 12, 15), c == 16, c);

        scn = "rstmid";
        for (int c = 0; c <= 15; c++)
            tick(c == 7, 1'b1, c == 0, 1'b0, (c <= 7) ? ph_rng(c, 3, 5, 9, 12) : 3'd0, 1'b0, c);

        scn = "after_rst";
        for (int c = 0; c <= 16; c++)
            tick(1'b0, 1'b1, c == 0, 1'b0, ph_rng(c, 3, 5, 9, 12), c == 13, c);

        scn = "frame";
        reset_dut();
        set_t(0, 0, 0, 3);
        for (int c = 0; c <= 24; c++)
            tick(1'b0, 1'b1, c == 0, c <= 19,
                 (c >= 1 && c <= 20) ? 3'(((c - 1) % 4) + 1) : 3'd0,
                 (c == 5) || (c == 9) || (c == 13) || (c == 17) || (c == 21), c);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 32'd0);
`ifdef VTIM_GEN_FRAME_CNT_EN
        chk("frm_final", {30'd0, bus.frame_cnt}, 32'd1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
